// File: rtl/lock_pkg.sv
// Shared definitions for the keypad password lock: key codes, FSM state
// encoding and the width of the OPEN/LOCKOUT hold timer.
package lock_pkg;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // 29 bits covers a 10 s hold at 50 MHz (499_999_999 < 2**29).
    localparam int TMR_W = 29;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INPUT,
        S_CHECK,
        S_OPEN,
        S_SET,
        S_LOCKOUT
    } state_t;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT holds; done pulses for
// one cycle in the last cycle of a load+1 cycle run.
module lock_timer
    import lock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [TMR_W-1:0] load,
    input  logic             clear,
    output logic             done
);

    logic [TMR_W-1:0] cnt;
    logic             run;

    assign done = run && (cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            cnt <= load;
            run <= 1'b1;
        end else if (run) begin
            if (cnt == '0) run <= 1'b0;
            else           cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/pwd_check.sv
// Keypad password lock: collects BCD digits, checks them against a stored
// password, holds the lock open, allows a password change, and locks out after
// repeated wrong entries.
module pwd_check
    import lock_pkg::*;
#(
    parameter int          PWD_LEN  = 4,
    parameter logic [31:0] PWD_INIT = 32'h0000_1234,
    parameter int          MAX_ERR  = 3,
    parameter int          OPEN_CNT = 249_999_999,
    parameter int          LOCK_CNT = 499_999_999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_flag,
    input  logic [3:0] key_value,
    output logic       unlock,
    output logic       alarm,
    output logic       err_pulse,
    output logic [3:0] digit_cnt,
    output logic       set_mode
);

    localparam int               BW       = 4 * PWD_LEN;
    localparam int               EW       = $clog2(MAX_ERR + 1);
    localparam logic [3:0]       LEN_D    = 4'(PWD_LEN);
    localparam logic [EW-1:0]    ERR_MAX  = EW'(MAX_ERR);
    localparam logic [EW-1:0]    ERR_LAST = EW'(MAX_ERR - 1);
    localparam logic [TMR_W-1:0] OPEN_LD  = TMR_W'(OPEN_CNT);
    localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCK_CNT);

    state_t           state, next_state;
    logic [BW-1:0]    entry, pwd;
    logic [EW-1:0]    err_cnt;

    logic             is_digit, is_star, is_hash, can_shift, match;
    logic             buf_clr, buf_shift, pwd_wr, err_inc, err_clr, err_fire;
    logic             tmr_start, tmr_clr, tmr_done;
    logic [TMR_W-1:0] tmr_load;

    // Codes 12-15 decode to nothing and so fall through every state untouched.
    assign is_digit  = key_flag && (key_value <= 4'd9);
    assign is_star   = key_flag && (key_value == KEY_STAR);
    assign is_hash   = key_flag && (key_value == KEY_HASH);
    assign can_shift = (digit_cnt < LEN_D);
    assign match     = (digit_cnt == LEN_D) && (entry == pwd);

    assign unlock   = (state == S_OPEN) || (state == S_SET);
    assign set_mode = (state == S_SET);
    assign alarm    = (state == S_LOCKOUT);

    lock_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tmr_start),
        .load  (tmr_load),
        .clear (tmr_clr),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state;
        buf_clr    = 1'b0;
        buf_shift  = 1'b0;
        pwd_wr     = 1'b0;
        err_inc    = 1'b0;
        err_clr    = 1'b0;
        err_fire   = 1'b0;
        tmr_start  = 1'b0;
        tmr_clr    = 1'b0;
        tmr_load   = OPEN_LD;
        case (state)
            S_IDLE, S_INPUT: begin
                if (is_digit) begin
                    buf_shift  = can_shift;
                    next_state = S_INPUT;
                end else if (is_star) begin
                    buf_clr    = 1'b1;
                    next_state = S_IDLE;
                end else if (is_hash) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                buf_clr = 1'b1;
                if (match) begin
                    err_clr    = 1'b1;
                    tmr_start  = 1'b1;
                    next_state = S_OPEN;
                end else begin
                    err_fire = 1'b1;
                    err_inc  = 1'b1;
                    if (err_cnt == ERR_LAST) begin
                        tmr_start  = 1'b1;
                        tmr_load   = LOCK_LD;
                        next_state = S_LOCKOUT;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            S_OPEN: begin
                // Expiry wins over a key arriving in the same cycle.
                if (tmr_done) begin
                    next_state = S_IDLE;
                end else if (is_star) begin
                    tmr_clr    = 1'b1;
                    buf_clr    = 1'b1;
                    next_state = S_SET;
                end
            end
            S_SET: begin
                if (is_digit) begin
                    buf_shift = can_shift;
                end else if (is_star) begin
                    buf_clr = 1'b1;
                end else if (is_hash) begin
                    buf_clr = 1'b1;
                    if (digit_cnt == LEN_D) begin
                        pwd_wr     = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        err_fire = 1'b1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (tmr_done) begin
                    err_clr    = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: the stored password is reset on purpose, so every power-up or
    // reset returns to PWD_INIT and a changed password is never retained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry     <= '0;
            digit_cnt <= '0;
            pwd       <= PWD_INIT[BW-1:0];
            err_cnt   <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_fire;
            if (buf_clr) begin
                entry     <= '0;
                digit_cnt <= '0;
            end else if (buf_shift) begin
                entry     <= (entry << 4) | BW'(key_value);
                digit_cnt <= digit_cnt + 4'd1;
            end
            if (pwd_wr) pwd <= entry;
            // Saturating, so the count cannot wrap past MAX_ERR.
            if (err_clr)                            err_cnt <= '0;
            else if (err_inc && err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pwd_check.md
PWD_CHECK -- requirements
Module: pwd_check

Interface
REQ-001 SHALL have parameter PWD_LEN, default 4, meaning number of BCD digits in the password (1..8).
REQ-002 SHALL have parameter PWD_INIT, default 32'h0000_1234, meaning the power-on password, BCD, with the low PWD_LEN nibbles used and digit 0 entered last.
REQ-003 SHALL have parameter MAX_ERR, default 3, meaning consecutive wrong entries that trigger lockout.
REQ-004 SHALL have parameter OPEN_CNT, default 249_999_999, meaning unlock hold time in clk cycles minus 1 (5 s at 50 MHz).
REQ-005 SHALL have parameter LOCK_CNT, default 499_999_999, meaning lockout time in clk cycles minus 1 (10 s).
REQ-006 clk  input  1  system clock; one clock domain only.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 key_flag  input  1  one-cycle pulse from the keypad scanner marking a new key press.
REQ-009 key_value  input  4  key code (0-9 digits, 10 '*', 11 '#'), sampled only while key_flag=1; may be X otherwise.
REQ-010 unlock  output  1  lock actuator drive, 1 = open.
REQ-011 alarm  output  1  1 during lockout.
REQ-012 err_pulse  output  1  one-cycle pulse for each rejected entry.
REQ-013 digit_cnt  output  4  digits currently buffered, for the display.
REQ-014 set_mode  output  1  1 while a new password is being entered.

Function
REQ-015 SHALL implement the states IDLE, INPUT, CHECK, OPEN, SET and LOCKOUT.
REQ-016 SHALL treat key_value 12-15 with key_flag=1 as no-ops in all states.
REQ-017 In IDLE or INPUT, a digit key SHALL shift into the entry buffer and increment digit_cnt; the state moves to INPUT.
REQ-018 digit_cnt SHALL saturate at PWD_LEN; further digits are ignored and the buffer is unchanged.
REQ-019 In INPUT, '*' SHALL clear the buffer and digit_cnt, and return to IDLE.
REQ-020 '#' SHALL move the FSM to CHECK for exactly 1 cycle.
REQ-021 In CHECK, a match requires both digit_cnt==PWD_LEN and buffer==stored password.
REQ-022 On a CHECK match: go to OPEN, clear the error count, and assert unlock starting the next cycle.
REQ-023 On a CHECK mismatch: pulse err_pulse, increment the error count, and go to LOCKOUT if the new count equals MAX_ERR, else to IDLE.
REQ-024 The buffer and digit_cnt SHALL be cleared on every exit from CHECK.
REQ-025 '#' pressed in IDLE with digit_cnt=0 SHALL be rejected as a mismatch.
REQ-026 OPEN SHALL hold unlock=1 for OPEN_CNT+1 cycles, then return to IDLE with unlock=0.
REQ-027 In OPEN, digits and '#' SHALL be ignored.
REQ-028 In OPEN, '*' SHALL go to SET and stop the open timer.
REQ-029 In SET, unlock=1 and set_mode=1, and digits buffer as in REQ-017/018.
REQ-030 In SET, '*' SHALL clear the buffer and remain in SET.
REQ-031 In SET, '#' with digit_cnt==PWD_LEN SHALL write the buffer to the stored password and go to IDLE.
REQ-032 In SET, '#' with digit_cnt<PWD_LEN SHALL pulse err_pulse, clear the buffer, and remain in SET; it SHALL NOT count toward MAX_ERR.
REQ-033 LOCKOUT SHALL assert alarm=1 and ignore all keys for LOCK_CNT+1 cycles, then clear the error count and alarm and go to IDLE.
REQ-034 A key_flag pulse arriving on the same cycle as a timer expiry SHALL be ignored.
REQ-035 The error count SHALL be wide enough for MAX_ERR and SHALL never wrap.

Reset
REQ-036 Asserting rst_n=0 at any time, including mid-entry, OPEN, SET or LOCKOUT, SHALL immediately force the following: state IDLE, unlock 0, alarm 0, err_pulse 0, set_mode 0, digit_cnt 0, buffer 0, error count 0, timer 0, stored password PWD_INIT.
REQ-037 The password SHALL NOT be retained across reset.

Structure
REQ-038 Package lock_pkg SHALL hold the key codes (KEY_STAR=10, KEY_HASH=11), the state encoding, and the timer width (29 bits).
REQ-039 Sub-module lock_timer SHALL hold a loadable down-counter with start, clear and done pulse, shared by OPEN and LOCKOUT.

Verification
REQ-040 Scenario: keys 1,2,3,4,# -> unlock rises 2 cycles after the '#' pulse, stays 1 for OPEN_CNT+1 cycles, then falls.
REQ-041 Scenario: keys 1,2,3,5,# three times -> three err_pulse pulses, then alarm=1 for LOCK_CNT+1 cycles; during it, 1,2,3,4,# does not unlock.
REQ-042 Scenario: keys 1,2,3,4,5,6,# -> unlock (digits 5 and 6 ignored); keys 1,2,# -> err_pulse.
REQ-043 Scenario: unlock, then *,9,8,7,6,# -> IDLE; old code 1234 rejected; 9876 unlocks.
REQ-044 Scenario: 1,2,*,1,2,3,4,# -> unlock; key_value=13 with a flag -> no state change.
REQ-045 Scenario: rst_n pulsed low during OPEN and during LOCKOUT -> all outputs return to reset values asynchronously; 1234 unlocks afterwards.
